// File: rtl/axis_alu_pipe_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// axis_alu_pipe_if -- AXI-Stream operand/result bundle for axis_alu_pipe
// Rev 1.0
// ------------------------------------------------------------------------
interface axis_alu_pipe_if #(
  parameter int OP0_WIDTH  = 16,
  parameter int OP1_WIDTH  = 16,
  parameter int RSLT_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int USER_WIDTH = 1
);
  logic [LANES*OP0_WIDTH-1:0]  s_axis_tdata_op0;
  logic [LANES*OP1_WIDTH-1:0]  s_axis_tdata_op1;
  logic [2:0]                  s_axis_top;
  logic                        s_axis_tlast;
  logic                        s_axis_tvalid;
  logic [USER_WIDTH-1:0]       s_axis_tuser;
  logic                        s_axis_tready;

  logic [LANES*RSLT_WIDTH-1:0] m_axis_tdata;
  logic [LANES-1:0]            m_axis_tovf;
  logic                        m_axis_terr;
  logic                        m_axis_tlast;
  logic                        m_axis_tvalid;
  logic [USER_WIDTH-1:0]       m_axis_tuser;
  logic                        m_axis_tready;

  // Environment side: sources operand beats and sinks results.
  modport master (
    output s_axis_tdata_op0, s_axis_tdata_op1, s_axis_top, s_axis_tlast,
           s_axis_tvalid, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tovf, m_axis_terr,
           m_axis_tlast, m_axis_tvalid, m_axis_tuser
  );

  modport slave (
    input  s_axis_tdata_op0, s_axis_tdata_op1, s_axis_top, s_axis_tlast,
           s_axis_tvalid, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tovf, m_axis_terr,
           m_axis_tlast, m_axis_tvalid, m_axis_tuser
  );
endinterface
`default_nettype wire

// File: rtl/axis_alu_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// axis_alu_pipe -- lane-parallel signed ALU/MAC on a stalling AXIS pipeline
// Rev 1.0
// ------------------------------------------------------------------------
module axis_alu_pipe #(
  parameter int OP0_WIDTH   = 16,
  parameter int OP1_WIDTH   = 16,
  parameter int RSLT_WIDTH  = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int SAT_ENABLE  = 1,
  parameter int USER_WIDTH  = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  axis_alu_pipe_if.slave bus
);
  localparam int FW   = (ACC_WIDTH > RSLT_WIDTH) ? ACC_WIDTH : RSLT_WIDTH;
  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MLT = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd5;
  localparam logic [2:0] OP_MAC = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic signed [FW-1:0] R_ONE = FW'(1);
  localparam logic signed [FW-1:0] R_MAX = (R_ONE <<< (RSLT_WIDTH - 1)) - R_ONE;
  localparam logic signed [FW-1:0] R_MIN = ~R_MAX;

  logic                        advance;
  logic                        accept;
  logic                        in_vld;
  logic [LANES*RSLT_WIDTH-1:0] res_d;
  logic [LANES-1:0]            ovf_d;
  logic                        err_d;

  logic [PIPE_STAGES-1:0]      vld_q;
  logic [LANES*RSLT_WIDTH-1:0] data_q [PIPE_STAGES];
  logic [LANES-1:0]            ovf_q  [PIPE_STAGES];
  logic                        err_q  [PIPE_STAGES];
  logic                        last_q [PIPE_STAGES];
  logic [USER_WIDTH-1:0]       user_q [PIPE_STAGES];

  // Single global stall: every stage moves only when the output slot frees up.
  assign advance           = !vld_q[LAST] || bus.m_axis_tready;
  assign bus.s_axis_tready = rst && advance;
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  // Mid-packet MAC beats only feed the accumulator.
  assign in_vld            = accept && !(bus.s_axis_top == OP_MAC && !bus.s_axis_tlast);
  assign err_d             = (bus.s_axis_top == OP_ILL);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [OP0_WIDTH-1:0] op0_w;
    logic signed [OP1_WIDTH-1:0] op1_w;
    logic signed [FW-1:0]        a_w;
    logic signed [FW-1:0]        b_w;
    logic signed [FW-1:0]        prod_w;
    logic signed [FW-1:0]        full_w;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_sum_w;
    logic [RSLT_WIDTH-1:0]       res_w;
    logic                        fits_w;

    assign op0_w     = bus.s_axis_tdata_op0[l*OP0_WIDTH +: OP0_WIDTH];
    assign op1_w     = bus.s_axis_tdata_op1[l*OP1_WIDTH +: OP1_WIDTH];
    assign a_w       = FW'(op0_w);
    assign b_w       = FW'(op1_w);
    assign prod_w    = a_w * b_w;
    assign acc_sum_w = acc_q + prod_w[ACC_WIDTH-1:0];

    always_comb begin
      full_w = '0;
      case (bus.s_axis_top)
        OP_ADD:  full_w = a_w + b_w;
        OP_SUB:  full_w = a_w - b_w;
        OP_MLT:  full_w = prod_w;
        OP_ABS:  full_w = a_w[FW-1] ? -a_w : a_w;
        OP_MIN:  full_w = (a_w < b_w) ? a_w : b_w;
        OP_MAX:  full_w = (a_w > b_w) ? a_w : b_w;
        OP_MAC:  full_w = FW'(acc_sum_w);
        default: full_w = '0;
      endcase

      fits_w = (full_w <= R_MAX) && (full_w >= R_MIN);
      if (fits_w || SAT_ENABLE == 0) begin
        res_w = full_w[RSLT_WIDTH-1:0];
      end else if (full_w > R_MAX) begin
        res_w = R_MAX[RSLT_WIDTH-1:0];
      end else begin
        res_w = R_MIN[RSLT_WIDTH-1:0];
      end

      acc_d = acc_q;
      if (accept && bus.s_axis_top == OP_MAC) begin
        acc_d = bus.s_axis_tlast ? '0 : acc_sum_w;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign res_d[l*RSLT_WIDTH +: RSLT_WIDTH] = res_w;
    assign ovf_d[l]                          = !fits_w;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        ovf_q[s] <= '0;
        err_q[s] <= 1'b0;
      end
    end else if (advance) begin
      vld_q[0] <= in_vld;
      ovf_q[0] <= ovf_d;
      err_q[0] <= err_d;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        ovf_q[s] <= ovf_q[s-1];
        err_q[s] <= err_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      data_q[0] <= res_d;
      last_q[0] <= bus.s_axis_tlast;
      user_q[0] <= bus.s_axis_tuser;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        data_q[s] <= data_q[s-1];
        last_q[s] <= last_q[s-1];
        user_q[s] <= user_q[s-1];
      end
    end
  end

  assign bus.m_axis_tvalid = vld_q[LAST];
  assign bus.m_axis_tdata  = data_q[LAST];
  assign bus.m_axis_tovf   = ovf_q[LAST];
  assign bus.m_axis_terr   = err_q[LAST];
  assign bus.m_axis_tlast  = last_q[LAST];
  assign bus.m_axis_tuser  = user_q[LAST];
endmodule
`default_nettype wire

// File: tb/tb_axis_alu_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_axis_alu_pipe -- directed vector bench for axis_alu_pipe
// Rev 1.0
// ------------------------------------------------------------------------
module tb_axis_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_alu_pipe_if #(.RSLT_WIDTH(32), .LANES(4)) ifa ();
  axis_alu_pipe_if #(.RSLT_WIDTH(16), .LANES(2)) ifb ();
  axis_alu_pipe_if #(.RSLT_WIDTH(16), .LANES(2)) ifc ();

  axis_alu_pipe dut_a (.clk(clk), .rst(rst), .bus(ifa));
  axis_alu_pipe #(.RSLT_WIDTH(16), .LANES(2), .PIPE_STAGES(1), .SAT_ENABLE(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  axis_alu_pipe #(.RSLT_WIDTH(16), .LANES(2), .PIPE_STAGES(1), .SAT_ENABLE(0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   ovf;
    logic         err;
    logic         last;
    logic         user;
    int           cyc;
  } out_t;

  out_t outq[$];
  int   acc_cyc[$];

  typedef struct packed {
    logic [2:0]        op;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [3:0][31:0]  e;
  } vec_a_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [1:0][15:0]  a;
    logic [1:0][15:0]  b;
    logic [1:0][15:0]  eb;
    logic [1:0]        ob;
    logic [1:0][15:0]  ec;
    logic [1:0]        oc;
  } vec_bc_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] p16(input int x0, input int x1, input int x2, input int x3);
    return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
  endfunction

  function automatic logic [127:0] p32(input int x0, input int x1, input int x2, input int x3);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [31:0] q16(input int x0, input int x1);
    return {x1[15:0], x0[15:0]};
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Output/accept monitor for dut_a, plus hold-stable check during stalls.
  logic         stall_prev = 1'b0;
  logic [127:0] pd;
  logic [3:0]   po;
  logic         pe, pl, pu;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stall_prev) begin
        chk("hold", {ifa.m_axis_tvalid, ifa.m_axis_tdata, ifa.m_axis_tovf, ifa.m_axis_terr,
                     ifa.m_axis_tlast, ifa.m_axis_tuser},
                    {1'b1, pd, po, pe, pl, pu});
      end
      if (ifa.s_axis_tvalid && ifa.s_axis_tready) acc_cyc.push_back(cyc);
      if (ifa.m_axis_tvalid && ifa.m_axis_tready)
        outq.push_back('{ifa.m_axis_tdata, ifa.m_axis_tovf, ifa.m_axis_terr,
                         ifa.m_axis_tlast, ifa.m_axis_tuser, cyc});
      stall_prev = ifa.m_axis_tvalid && !ifa.m_axis_tready;
      pd = ifa.m_axis_tdata; po = ifa.m_axis_tovf; pe = ifa.m_axis_terr;
      pl = ifa.m_axis_tlast; pu = ifa.m_axis_tuser;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic last, input logic user);
    int n;
    ifa.s_axis_top = op; ifa.s_axis_tdata_op0 = a; ifa.s_axis_tdata_op1 = b;
    ifa.s_axis_tlast = last; ifa.s_axis_tuser = user; ifa.s_axis_tvalid = 1'b1;
    #1;
    n = 0;
    while (!ifa.s_axis_tready && n < 60) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL send_timeout: got tready=0 required tready=1");
    end
    @(posedge clk); #1;
    ifa.s_axis_tvalid = 1'b0;
  endtask

  task automatic pop_out(input string nm, output out_t o, output bit ok);
    int n;
    n = 0;
    while (outq.size() == 0 && n < 60) begin
      @(posedge clk); #3; n++;
    end
    ok = (outq.size() != 0);
    if (ok) begin
      o = outq.pop_front();
    end else begin
      o = '{'0, '0, 1'b0, 1'b0, 1'b0, 0};
      checks++; failures++;
      $display("FAIL %s timeout: got no output required one beat", nm);
    end
  endtask

  vec_a_t  va [8];
  vec_bc_t vb [6];

  initial begin
    out_t o;
    bit   ok;
    int   ac;
    int   c0;

    va[0] = '{3'd0, p16(100, -5, 32767, -32768), p16(-30, -7, 32767, -32768),
              p32(70, -12, 65534, -65536)};
    va[1] = '{3'd1, p16(100, -32768, 0, 7), p16(-30, 32767, 5, 7),
              p32(130, -65535, -5, 0)};
    va[2] = '{3'd2, p16(-32768, 32767, -3, 0), p16(-32768, -32768, 4, 123),
              p32(1073741824, -1073709056, -12, 0)};
    va[3] = '{3'd3, p16(-32768, -1, 5, 0), p16(9, 9, 9, 9), p32(32768, 1, 5, 0)};
    va[4] = '{3'd4, p16(3, -100, 5, 32767), p16(-4, -99, 5, -32768),
              p32(-4, -100, 5, -32768)};
    va[5] = '{3'd5, p16(3, -100, 5, 32767), p16(-4, -99, 5, -32768),
              p32(3, -99, 5, 32767)};
    va[6] = '{3'd7, p16(1, 2, 3, 4), p16(5, 6, 7, 8), p32(0, 0, 0, 0)};
    va[7] = '{3'd6, p16(2, -4, 32767, 0), p16(3, 5, 32767, 0),
              p32(6, -20, 1073676289, 0)};

    vb[0] = '{3'd2, q16(-32768, 2), q16(-32768, 3), q16(32767, 6), 2'b01, q16(0, 6), 2'b01};
    vb[1] = '{3'd0, q16(32767, -32768), q16(1, -1), q16(32767, -32768), 2'b11,
              q16(-32768, 32767), 2'b11};
    vb[2] = '{3'd1, q16(-32768, 100), q16(1, -30), q16(-32768, 130), 2'b01,
              q16(32767, 130), 2'b01};
    vb[3] = '{3'd3, q16(-32768, -7), q16(0, 0), q16(32767, 7), 2'b01, q16(-32768, 7), 2'b01};
    vb[4] = '{3'd6, q16(-32768, 300), q16(-32768, 300), q16(32767, 32767), 2'b11,
              q16(0, 24464), 2'b11};
    vb[5] = '{3'd4, q16(-32768, 5), q16(32767, -6), q16(-32768, -6), 2'b00,
              q16(-32768, -6), 2'b00};

    rst = 1'b0;
    ifa.s_axis_tvalid = 1'b0; ifa.s_axis_tdata_op0 = '0; ifa.s_axis_tdata_op1 = '0;
    ifa.s_axis_top = '0; ifa.s_axis_tlast = 1'b0; ifa.s_axis_tuser = '0;
    ifa.m_axis_tready = 1'b1;
    ifb.s_axis_tvalid = 1'b0; ifb.s_axis_tdata_op0 = '0; ifb.s_axis_tdata_op1 = '0;
    ifb.s_axis_top = '0; ifb.s_axis_tlast = 1'b1; ifb.s_axis_tuser = '0;
    ifb.m_axis_tready = 1'b1;
    ifc.s_axis_tvalid = 1'b0; ifc.s_axis_tdata_op0 = '0; ifc.s_axis_tdata_op1 = '0;
    ifc.s_axis_top = '0; ifc.s_axis_tlast = 1'b1; ifc.s_axis_tuser = '0;
    ifc.m_axis_tready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {ifa.m_axis_tvalid, ifa.s_axis_tready, ifa.m_axis_tovf, ifa.m_axis_terr,
                        ifb.m_axis_tvalid, ifc.m_axis_tvalid}, '0);
    rst = 1'b1;
    #1;
    chk("ready after reset", ifa.s_axis_tready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      acc_cyc.delete();
      send_a(va[i].op, va[i].a, va[i].b, i[0], i[1]);
      pop_out($sformatf("A%0d", i), o, ok);
      if (ok) begin
        ac = acc_cyc.pop_front();
        chk($sformatf("A%0d data", i), o.data, va[i].e);
        chk($sformatf("A%0d flags", i), {o.ovf, o.err, o.last, o.user},
            {4'b0000, va[i].op == 3'd7, i[0], i[1]});
        chk($sformatf("A%0d latency", i), o.cyc - ac, 2);
      end
    end

    for (int i = 0; i < 6; i++) begin
      ifb.s_axis_top = vb[i].op; ifb.s_axis_tdata_op0 = vb[i].a;
      ifb.s_axis_tdata_op1 = vb[i].b; ifb.s_axis_tvalid = 1'b1;
      ifc.s_axis_top = vb[i].op; ifc.s_axis_tdata_op0 = vb[i].a;
      ifc.s_axis_tdata_op1 = vb[i].b; ifc.s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      ifb.s_axis_tvalid = 1'b0; ifc.s_axis_tvalid = 1'b0;
      chk($sformatf("SAT%0d", i), {ifb.m_axis_tvalid, ifb.m_axis_tdata, ifb.m_axis_tovf},
          {1'b1, vb[i].eb, vb[i].ob});
      chk($sformatf("WRAP%0d", i), {ifc.m_axis_tvalid, ifc.m_axis_tdata, ifc.m_axis_tovf},
          {1'b1, vb[i].ec, vb[i].oc});
    end

    // Back-to-back throughput with the sink always ready.
    acc_cyc.delete();
    for (int i = 0; i < 6; i++) send_a(3'd0, p16(i, i, i, i), p16(1000, 1000, 1000, 1000), 1'b0, 1'b0);
    chk("accept spacing", acc_cyc[5] - acc_cyc[0], 5);
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      pop_out("tput", o, ok);
      if (ok) begin
        if (i == 0) c0 = o.cyc;
        chk($sformatf("tput%0d data", i), o.data, p32(i + 1000, i + 1000, i + 1000, i + 1000));
        if (i == 5) chk("output spacing", o.cyc - c0, 5);
      end
    end

    // Ten beats under a sink that toggles ready every cycle.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          ifa.m_axis_tready = ~ifa.m_axis_tready;
        end
      end
      begin
        for (int i = 0; i < 10; i++)
          send_a(3'd0, p16(i*100, i*100+1, i*100+2, i*100+3), p16(-i, -i, -i, -i), i == 9, i[0]);
      end
    join
    ifa.m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pop_out("stream", o, ok);
      if (ok) chk($sformatf("stream%0d", i), {o.data, o.last, o.user},
                  {p32(i*99, i*99+1, i*99+2, i*99+3), i == 9, i[0]});
    end
    repeat (4) @(posedge clk);
    #1;
    chk("stream no extra", outq.size(), 0);

    // Three-beat MAC packet then a one-beat packet to confirm the clear.
    send_a(3'd6, p16(2, 1, 0, 0), p16(3, 1, 0, 0), 1'b0, 1'b0);
    send_a(3'd6, p16(4, 1, 0, 0), p16(5, 1, 0, 0), 1'b0, 1'b0);
    send_a(3'd6, p16(-1, 1, 0, 0), p16(6, 1, 0, 0), 1'b1, 1'b1);
    pop_out("mac3", o, ok);
    if (ok) chk("mac3", {o.data, o.last, o.user, o.err}, {p32(20, 3, 0, 0), 3'b110});
    repeat (4) @(posedge clk);
    #1;
    chk("mac3 single beat", outq.size(), 0);
    send_a(3'd6, p16(1, 0, 0, 0), p16(1, 0, 0, 0), 1'b1, 1'b0);
    pop_out("mac1", o, ok);
    if (ok) chk("mac1", o.data, p32(1, 0, 0, 0));

    // Illegal opcode inside a MAC packet.
    send_a(3'd6, p16(2, 0, 0, 0), p16(3, 0, 0, 0), 1'b0, 1'b0);
    send_a(3'd7, p16(9, 9, 9, 9), p16(9, 9, 9, 9), 1'b0, 1'b1);
    send_a(3'd6, p16(4, 0, 0, 0), p16(5, 0, 0, 0), 1'b1, 1'b0);
    pop_out("ill", o, ok);
    if (ok) chk("ill beat", {o.data, o.ovf, o.err, o.last, o.user}, {128'd0, 4'b0, 3'b101});
    pop_out("ill mac", o, ok);
    if (ok) chk("ill mac", {o.data, o.err, o.last}, {p32(26, 0, 0, 0), 2'b01});

    // Reset with a partial accumulation and two beats in flight.
    send_a(3'd6, p16(5, 0, 0, 0), p16(5, 0, 0, 0), 1'b0, 1'b0);
    send_a(3'd0, p16(1, 1, 1, 1), p16(1, 1, 1, 1), 1'b0, 1'b0);
    send_a(3'd0, p16(2, 2, 2, 2), p16(2, 2, 2, 2), 1'b0, 1'b0);
    ifa.m_axis_tready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid reset", {ifa.m_axis_tvalid, ifa.s_axis_tready, ifa.m_axis_tovf, ifa.m_axis_terr}, '0);
    rst = 1'b1;
    ifa.m_axis_tready = 1'b1;
    #1;
    chk("ready after mid reset", ifa.s_axis_tready, 1'b1);
    chk("flushed", outq.size(), 0);
    @(posedge clk); #1;
    send_a(3'd6, p16(2, 0, 0, 0), p16(2, 0, 0, 0), 1'b1, 1'b0);
    pop_out("post reset mac", o, ok);
    if (ok) chk("post reset mac", o.data, p32(4, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1;
    chk("post reset no extra", outq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axis_alu_pipe.md
AXIS_ALU_PIPE -- requirements
Module: axis_alu_pipe

Interface
REQ-001 Parameter OP0_WIDTH, default 16: signed width of operand 0 per lane.
REQ-002 Parameter OP1_WIDTH, default 16: signed width of operand 1 per lane.
REQ-003 Parameter RSLT_WIDTH, default 32: signed width of result per lane.
REQ-004 Parameter ACC_WIDTH, default 40: signed width of the MAC accumulator per lane; ACC_WIDTH SHALL be at least OP0_WIDTH+OP1_WIDTH.
REQ-005 Parameter LANES, default 4: number of parallel lanes sharing one handshake.
REQ-006 Parameter PIPE_STAGES, default 2: number of output pipeline registers; minimum 1.
REQ-007 Parameter SAT_ENABLE, default 1: 1 saturates results to RSLT_WIDTH, 0 truncates them (two's-complement wrap).
REQ-008 Parameter USER_WIDTH, default 1: width of tuser.
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 rst  input  1  synchronous, active-low reset.
REQ-011 s_axis_tdata_op0  input  LANES*OP0_WIDTH  lane-packed operand 0.
REQ-012 s_axis_tdata_op1  input  LANES*OP1_WIDTH  lane-packed operand 1.
REQ-013 s_axis_top  input  3  per-beat opcode: 0 ADD, 1 SUB, 2 MLT, 3 ABS(op0), 4 MIN, 5 MAX, 6 MAC; 7 illegal.
REQ-014 s_axis_tlast / s_axis_tvalid / s_axis_tuser  input  1/1/USER_WIDTH  standard AXI-Stream sideband.
REQ-015 s_axis_tready  output  1  input ready.
REQ-016 m_axis_tdata  output  LANES*RSLT_WIDTH  lane-packed results.
REQ-017 m_axis_tovf  output  LANES  per-lane flag; set when the result was saturated or wrapped.
REQ-018 m_axis_terr  output  1  set when the beat carried opcode 7.
REQ-019 m_axis_tlast / m_axis_tvalid / m_axis_tuser  output  1/1/USER_WIDTH; m_axis_tready  input  1.

Function
REQ-020 The module SHALL accept a beat when s_axis_tvalid=1 and s_axis_tready=1.
REQ-021 s_axis_tready SHALL equal !(last stage valid) || m_axis_tready; the whole pipeline advances only while this holds. No internal bubbles are permitted, and the module SHALL sustain one beat per cycle under continuous m_axis_tready=1.
REQ-022 The result SHALL appear on m_axis_tvalid exactly PIPE_STAGES cycles after acceptance when not stalled; each stall cycle adds one cycle.
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs SHALL hold stable.
REQ-024 Opcodes 0-5 SHALL be computed per lane at full internal precision from the signed operands, then saturated or wrapped to RSLT_WIDTH per SAT_ENABLE, with m_axis_tovf set per lane when the value did not fit.
REQ-025 ABS of the most-negative op0 SHALL produce +2^(OP0_WIDTH-1) when that value fits in RSLT_WIDTH; otherwise it saturates and sets tovf.
REQ-026 MAC: each accepted MAC beat SHALL update acc[lane] += op0*op1 in ACC_WIDTH with wrap-around. A non-tlast MAC beat SHALL be consumed without entering the output pipeline. The tlast MAC beat SHALL emit the updated accumulator (saturated or wrapped to RSLT_WIDTH) and clear acc to 0 in the same cycle.
REQ-027 A non-MAC beat arriving mid-packet SHALL NOT modify or clear the accumulator; the accumulator persists until the next tlast MAC beat.
REQ-028 Opcode 7 SHALL produce tdata=0, tovf=0, and terr=1, and SHALL NOT modify the accumulator.
REQ-029 tlast and tuser SHALL travel with their beat through the pipeline unchanged.

Reset
REQ-030 While rst=0 at a clock edge: all stage valids clear, accumulators clear to 0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tovf=0, and m_axis_terr=0.
REQ-031 On the first edge after rst returns to 1, s_axis_tready SHALL be 1. Beats in flight or partially accumulated at reset are discarded.
REQ-032 Data registers need no reset; outputs other than those listed in REQ-030 are don't-care while m_axis_tvalid=0.

Verification
REQ-033 Defaults, ADD, lane0 op0=100, op1=-30, m_axis_tready=1 -> tdata lane0 = 70 exactly 2 cycles after acceptance; tovf=0.
REQ-034 RSLT_WIDTH=16, SAT_ENABLE=1, MLT, op0=op1=-32768 -> lane result 32767, tovf=1; with SAT_ENABLE=0 -> 0, tovf=1.
REQ-035 MAC packet of 3 beats, lane0 products 2*3, 4*5, -1*6 -> only one output beat, value 20 with tlast=1; a following 1-beat MAC packet of 1*1 -> 1, confirming the accumulator was cleared.
REQ-036 Stream 10 ADD beats with m_axis_tready toggling 1/0 each cycle -> all 10 results delivered in order, none lost or duplicated, outputs stable during stalls.
REQ-037 Opcode 7 beat between two MAC beats of one packet -> terr=1, tdata=0 output, and the MAC sum is unaffected.
REQ-038 Assert rst=0 mid-packet with 2 beats in flight -> next cycle m_axis_tvalid=0; after release, a 1-beat MAC packet of 2*2 yields 4.
